// File: rtl/circ_sweep_pkg.sv
// Shared encodings and constants for the circ340 self-test sweep.
// Golden masks give bit i = expected output for input vector i = {a,b,c,d}.
package circ_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int NVEC  = 16;
    localparam int IDX_W = 4;

    localparam logic [NVEC-1:0] CIRC340_E_GOLD = 16'hFFCA;
    localparam logic [NVEC-1:0] CIRC340_F_GOLD = 16'h1C1C;

    // Vector index as driven onto the circ340 inputs, a is the MSB.
    function automatic logic [IDX_W-1:0] vec_idx(input logic a, input logic b,
                                                 input logic c, input logic d);
        return {a, b, c, d};
    endfunction

endpackage

// File: rtl/circ340_sweep_ctrl_if.sv
// Host/datapath-facing signal bundle of the sweep controller.
// master = host side (start/abort plus the circ340 outputs), slave = controller.
interface circ340_sweep_ctrl_if;
    import circ_sweep_pkg::*;

    logic             start;
    logic             abort;
    logic             e_in;
    logic             f_in;
    logic             a_out;
    logic             b_out;
    logic             c_out;
    logic             d_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [NVEC-1:0]  e_tbl;
    logic [NVEC-1:0]  f_tbl;
    logic [IDX_W:0]   err_cnt;
    logic [IDX_W-1:0] first_err;
    logic             first_err_vld;

    modport master (
        output start, abort, e_in, f_in,
        input  a_out, b_out, c_out, d_out, busy, done, pass,
               e_tbl, f_tbl, err_cnt, first_err, first_err_vld
    );

    modport slave (
        input  start, abort, e_in, f_in,
        output a_out, b_out, c_out, d_out, busy, done, pass,
               e_tbl, f_tbl, err_cnt, first_err, first_err_vld
    );

endinterface

// File: rtl/circ340.sv
// circ340 combinational datapath: E,F = f(A,B,C,D).
// E is high for a=1 and for vectors 1,3,6,7; F is high for {b,c,d} in {010,011,100}.
module circ340 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_d,
    output logic o_e,
    output logic o_f
);

    assign o_e = i_a | (~i_b & i_d) | (i_b & i_c);
    assign o_f = (~i_b & i_c) | (i_b & ~i_c & ~i_d);

endmodule

// File: rtl/circ340_selftest_top.sv
// Integration wrapper: one sweep controller driving one circ340 instance.
module circ340_selftest_top
    import circ_sweep_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [NVEC-1:0]  o_e_tbl,
    output logic [NVEC-1:0]  o_f_tbl,
    output logic [IDX_W:0]   o_err_cnt,
    output logic [IDX_W-1:0] o_first_err,
    output logic             o_first_err_vld,
    output logic [IDX_W-1:0] o_vec
);

    circ340_sweep_ctrl_if u_bus ();

    assign u_bus.start = i_start;
    assign u_bus.abort = i_abort;

    circ340_sweep_ctrl #(
        .SETTLE (SETTLE),
        .E_GOLD (CIRC340_E_GOLD),
        .F_GOLD (CIRC340_F_GOLD)
    ) u_ctrl (
        .clk (clk),
        .rst (rst),
        .bus (u_bus.slave)
    );

    circ340 u_dp (
        .i_a (u_bus.a_out),
        .i_b (u_bus.b_out),
        .i_c (u_bus.c_out),
        .i_d (u_bus.d_out),
        .o_e (u_bus.e_in),
        .o_f (u_bus.f_in)
    );

    assign o_busy          = u_bus.busy;
    assign o_done          = u_bus.done;
    assign o_pass          = u_bus.pass;
    assign o_e_tbl         = u_bus.e_tbl;
    assign o_f_tbl         = u_bus.f_tbl;
    assign o_err_cnt       = u_bus.err_cnt;
    assign o_first_err     = u_bus.first_err;
    assign o_first_err_vld = u_bus.first_err_vld;
    assign o_vec           = vec_idx(u_bus.a_out, u_bus.b_out, u_bus.c_out, u_bus.d_out);

endmodule

// File: rtl/circ340_sweep_ctrl.sv
// Sweeps all 16 circ340 input vectors, captures E/F truth tables after a settle
// window and grades them against golden masks (pass, error count, first failing index).
module circ340_sweep_ctrl
    import circ_sweep_pkg::*;
#(
    parameter int unsigned      SETTLE = 1,
    parameter logic [NVEC-1:0]  E_GOLD = CIRC340_E_GOLD,
    parameter logic [NVEC-1:0]  F_GOLD = CIRC340_F_GOLD
) (
    input logic                 clk,
    input logic                 rst,
    circ340_sweep_ctrl_if.slave bus
);

    localparam logic [IDX_W-1:0] SETTLE_C = IDX_W'(SETTLE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NVEC - 1);
    localparam logic [IDX_W:0]   ONE_ERR  = (IDX_W + 1)'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_cnt;
    logic [NVEC-1:0]  r_e_tbl;
    logic [NVEC-1:0]  r_f_tbl;
    logic [IDX_W:0]   r_err_cnt;
    logic [IDX_W-1:0] r_first_err;
    logic             r_first_err_vld;
    logic             r_pass;

    logic             w_clear;
    logic             w_tick;
    logic             w_sample;
    logic             w_last;
    logic             w_mis;
    logic [NVEC-1:0]  w_e_tbl;
    logic [NVEC-1:0]  w_f_tbl;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // abort wins over a sample falling on the same edge
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_tick      = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_state_nxt = ST_APPLY;
                    w_clear     = 1'b1;
                end
            end
            ST_APPLY: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == SETTLE_C) begin
                    w_sample = 1'b1;
                    if (w_last) w_state_nxt = ST_DONE;
                end else begin
                    w_tick = 1'b1;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_last = (r_idx == LAST_IDX);
    assign w_mis  = (bus.e_in != E_GOLD[r_idx]) || (bus.f_in != F_GOLD[r_idx]);

    // tables with the current sample merged in, so pass can see vector 15
    always_comb begin
        w_e_tbl        = r_e_tbl;
        w_f_tbl        = r_f_tbl;
        w_e_tbl[r_idx] = bus.e_in;
        w_f_tbl[r_idx] = bus.f_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx           <= '0;
            r_cnt           <= '0;
            r_e_tbl         <= '0;
            r_f_tbl         <= '0;
            r_err_cnt       <= '0;
            r_first_err     <= '0;
            r_first_err_vld <= 1'b0;
            r_pass          <= 1'b0;
        end else if (w_clear) begin
            r_idx           <= '0;
            r_cnt           <= '0;
            r_e_tbl         <= '0;
            r_f_tbl         <= '0;
            r_err_cnt       <= '0;
            r_first_err     <= '0;
            r_first_err_vld <= 1'b0;
            r_pass          <= 1'b0;
        end else if (w_tick) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (w_sample) begin
            r_e_tbl <= w_e_tbl;
            r_f_tbl <= w_f_tbl;
            r_cnt   <= '0;
            if (w_mis) begin
                r_err_cnt <= r_err_cnt + ONE_ERR;
                if (!r_first_err_vld) begin
                    r_first_err     <= r_idx;
                    r_first_err_vld <= 1'b1;
                end
            end
            // idx parks on the last vector through DONE/IDLE
            if (w_last) r_pass <= (w_e_tbl == E_GOLD) && (w_f_tbl == F_GOLD);
            else        r_idx  <= r_idx + 1'b1;
        end
    end

    assign bus.a_out         = r_idx[3];
    assign bus.b_out         = r_idx[2];
    assign bus.c_out         = r_idx[1];
    assign bus.d_out         = r_idx[0];
    assign bus.busy          = (r_state == ST_APPLY);
    assign bus.done          = (r_state == ST_DONE);
    assign bus.pass          = r_pass;
    assign bus.e_tbl         = r_e_tbl;
    assign bus.f_tbl         = r_f_tbl;
    assign bus.err_cnt       = r_err_cnt;
    assign bus.first_err     = r_first_err;
    assign bus.first_err_vld = r_first_err_vld;

endmodule

// File: tb/tb_circ340_sweep_ctrl.sv
// Directed + randomized bench for the circ340 sweep controller and its wrapper.
// Expected results come from truth-table arithmetic against the golden masks.
module tb_circ340_sweep_ctrl;
    import circ_sweep_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // wrapper with the real circ340
    logic        w_start = 1'b0, w_abort = 1'b0;
    logic        w_busy, w_done, w_pass, w_fev;
    logic [15:0] w_etbl, w_ftbl;
    logic [4:0]  w_ecnt;
    logic [3:0]  w_fe, w_vec;

    circ340_selftest_top #(.SETTLE(1)) u_top (
        .clk (clk), .rst (rst), .i_start (w_start), .i_abort (w_abort),
        .o_busy (w_busy), .o_done (w_done), .o_pass (w_pass),
        .o_e_tbl (w_etbl), .o_f_tbl (w_ftbl), .o_err_cnt (w_ecnt),
        .o_first_err (w_fe), .o_first_err_vld (w_fev), .o_vec (w_vec)
    );

    // controllers whose circ340 behaviour is a bench-chosen truth table
    logic [15:0] tt_e1 = CIRC340_E_GOLD, tt_f1 = CIRC340_F_GOLD;
    logic [15:0] tt_e0 = CIRC340_E_GOLD, tt_f0 = CIRC340_F_GOLD;

    circ340_sweep_ctrl_if bus1 ();
    circ340_sweep_ctrl_if bus0 ();

    assign bus1.e_in = tt_e1[{bus1.a_out, bus1.b_out, bus1.c_out, bus1.d_out}];
    assign bus1.f_in = tt_f1[{bus1.a_out, bus1.b_out, bus1.c_out, bus1.d_out}];
    assign bus0.e_in = tt_e0[{bus0.a_out, bus0.b_out, bus0.c_out, bus0.d_out}];
    assign bus0.f_in = tt_f0[{bus0.a_out, bus0.b_out, bus0.c_out, bus0.d_out}];

    circ340_sweep_ctrl #(.SETTLE(1), .E_GOLD(CIRC340_E_GOLD), .F_GOLD(CIRC340_F_GOLD))
        u_dut1 (.clk (clk), .rst (rst), .bus (bus1));
    circ340_sweep_ctrl #(.SETTLE(0), .E_GOLD(CIRC340_E_GOLD), .F_GOLD(CIRC340_F_GOLD))
        u_dut0 (.clk (clk), .rst (rst), .bus (bus0));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs1();
        return 64'({bus1.busy, bus1.done, bus1.pass, bus1.e_tbl, bus1.f_tbl, bus1.err_cnt,
                    bus1.first_err, bus1.first_err_vld,
                    bus1.a_out, bus1.b_out, bus1.c_out, bus1.d_out});
    endfunction

    // Reference grading of a captured pair of truth tables.
    task automatic grade(input string tag, input logic [15:0] te, input logic [15:0] tf,
                         input logic [15:0] oe, input logic [15:0] of_, input logic [4:0] ocnt,
                         input logic [3:0] ofe, input logic ovld, input logic opass);
        logic [15:0] diff;
        int          fe;
        diff = (te ^ CIRC340_E_GOLD) | (tf ^ CIRC340_F_GOLD);
        fe   = 0;
        for (int i = 15; i >= 0; i--) if (diff[i]) fe = i;
        chk({tag, "_etbl"}, 64'(oe),   64'(te));
        chk({tag, "_ftbl"}, 64'(of_),  64'(tf));
        chk({tag, "_err"},  64'(ocnt), 64'($countones(diff)));
        chk({tag, "_fvld"}, 64'(ovld), 64'(diff != 16'h0));
        chk({tag, "_ferr"}, 64'(ofe),  64'(fe));
        chk({tag, "_pass"}, 64'(opass), 64'(diff == 16'h0));
    endtask

    // Full SETTLE=1 sweep on dut1; call at a negedge with dut1 idle.
    task automatic run1(input string tag, input logic [15:0] te, input logic [15:0] tf);
        int k;
        tt_e1 = te;
        tt_f1 = tf;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        chk({tag, "_busy"}, 64'(bus1.busy), 64'd1);
        k = 0;
        while (!bus1.done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, 64'(k), 64'd32);
        chk({tag, "_busy_at_done"}, 64'(bus1.busy), 64'd0);
        grade(tag, te, tf, bus1.e_tbl, bus1.f_tbl, bus1.err_cnt,
              bus1.first_err, bus1.first_err_vld, bus1.pass);
        chk({tag, "_vec_hold"}, 64'({bus1.a_out, bus1.b_out, bus1.c_out, bus1.d_out}), 64'd15);
        @(negedge clk);
        chk({tag, "_idle"}, 64'({bus1.done, bus1.busy}), 64'd0);
    endtask

    initial begin
        int k;
        int nd;
        logic b33, b34;
        bus1.start = 1'b0; bus1.abort = 1'b0;
        bus0.start = 1'b0; bus0.abort = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_dut1", outs1(), 64'd0);
        chk("rst_top", 64'({w_busy, w_done, w_pass, w_etbl, w_ftbl, w_ecnt, w_fe, w_fev, w_vec}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // real circ340 through the wrapper
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        k = 0;
        while (!w_done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("top_lat", 64'(k), 64'd32);
        chk("top_etbl", 64'(w_etbl), 64'h FFCA);
        chk("top_ftbl", 64'(w_ftbl), 64'h1C1C);
        chk("top_res", 64'({w_pass, w_ecnt, w_fev}), 64'({1'b1, 5'd0, 1'b0}));
        @(negedge clk);
        chk("top_done_1cyc", 64'(w_done), 64'd0);

        // F stuck-at-0 with real E
        run1("stuckf", CIRC340_E_GOLD, 16'h0000);
        chk("stuckf_spec", 64'({bus1.err_cnt, bus1.first_err, bus1.first_err_vld}),
            64'({5'd6, 4'd2, 1'b1}));

        // random faulty circuits, then a clean one
        for (int t = 0; t < 4; t++) run1("rand", 16'($urandom), 16'($urandom));
        run1("gold", CIRC340_E_GOLD, CIRC340_F_GOLD);

        // abort 10 cycles into the sweep
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (9) @(negedge clk);
        bus1.abort = 1'b1;
        @(negedge clk);
        bus1.abort = 1'b0;
        chk("abort_busy", 64'(bus1.busy), 64'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus1.done) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        chk("abort_pass", 64'(bus1.pass), 64'd0);
        run1("after_abort", CIRC340_E_GOLD, CIRC340_F_GOLD);

        // start held high: one done per sweep, restart only from IDLE
        bus1.start = 1'b1;
        @(negedge clk);
        nd = 0; b33 = 1'b1; b34 = 1'b0;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            if (i <= 33 && bus1.done) nd++;
            if (i == 33) b33 = bus1.busy;
            if (i == 34) b34 = bus1.busy;
        end
        chk("held_one_done", 64'(nd), 64'd1);
        chk("held_idle_gap", 64'(b33), 64'd0);
        chk("held_restart", 64'(b34), 64'd1);
        bus1.start = 1'b0;
        bus1.abort = 1'b1;
        @(negedge clk);
        bus1.abort = 1'b0;
        chk("held_abort", 64'(bus1.busy), 64'd0);

        // SETTLE=0: one vector per cycle
        tt_e0 = 16'($urandom);
        tt_f0 = 16'($urandom);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        nd = 0;
        for (int j = 0; j < 16; j++) begin
            if ({bus0.a_out, bus0.b_out, bus0.c_out, bus0.d_out} != 4'(j)) nd++;
            @(negedge clk);
        end
        chk("s0_vec_steps_bad", 64'(nd), 64'd0);
        chk("s0_done", 64'(bus0.done), 64'd1);
        grade("s0", tt_e0, tt_f0, bus0.e_tbl, bus0.f_tbl, bus0.err_cnt,
              bus0.first_err, bus0.first_err_vld, bus0.pass);
        @(negedge clk);
        chk("s0_done_1cyc", 64'(bus0.done), 64'd0);

        // reset mid-sweep, with start presented on the same edge
        tt_e1 = CIRC340_E_GOLD;
        tt_f1 = 16'h0000;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 64'(bus1.busy), 64'd1);
        rst = 1'b1;
        bus1.start = 1'b1;
        @(negedge clk);
        chk("midrst_outs", outs1(), 64'd0);
        rst = 1'b0;
        bus1.start = 1'b0;
        @(negedge clk);
        chk("midrst_idle", 64'(bus1.busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
